// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM controller port between two requesters.
// Optional macro SDRAM_ARB_LOCK_EN adds p0_lock/p1_lock to keep ownership across burst words.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         p0_req,
    input  logic                         p0_we,
    input  logic [ADDR_W-1:0]            p0_addr,
    input  logic [DATA_W-1:0]            p0_din,
    output logic                         p0_ack,
    output logic                         p0_valid,
    output logic [DATA_W-1:0]            p0_dout,
    input  logic                         p1_req,
    input  logic                         p1_we,
    input  logic [ADDR_W-1:0]            p1_addr,
    input  logic [DATA_W-1:0]            p1_din,
    output logic                         p1_ack,
    output logic                         p1_valid,
    output logic [DATA_W-1:0]            p1_dout,
`ifdef SDRAM_ARB_LOCK_EN
    input  logic                         p0_lock,
    input  logic                         p1_lock,
`endif
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_din,
    input  logic                         mem_ack,
    input  logic                         mem_valid,
    input  logic [DATA_W-1:0]            mem_dout,
    output logic [$clog2(MAX_PENDING):0] pending,
    output logic                         err_orphan
);

    localparam int PW = $clog2(MAX_PENDING) + 1;
    localparam int AW = $clog2(MAX_PENDING);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_din_q, mem_din_d;
    logic [MAX_PENDING-1:0]  fifo_q, fifo_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    not_full;
    logic                    elig0, elig1;
    logic                    sel;
    logic                    push, pop;
    logic                    head;

`ifdef SDRAM_ARB_LOCK_EN
    logic                    lock_hold_q, lock_hold_d;
    logic                    lock_own_q, lock_own_d;
    logic                    held_elig;
`endif

    assign not_full = cnt_q < PW'(MAX_PENDING);
    assign elig0    = p0_req & (p0_we | not_full);
    assign elig1    = p1_req & (p1_we | not_full);
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = mem_valid & (cnt_q != '0);

`ifdef SDRAM_ARB_LOCK_EN
    assign held_elig = lock_own_q ? elig1 : elig0;
`endif

    // Round-robin pick; a held burst owner overrides it while still eligible
    always_comb begin
        sel = 1'b0;
        if (elig0 && elig1) begin
            sel = ~last_grant_q;
        end else if (elig1) begin
            sel = 1'b1;
        end
`ifdef SDRAM_ARB_LOCK_EN
        if (lock_hold_q && held_elig) begin
            sel = lock_own_q;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        push         = 1'b0;
`ifdef SDRAM_ARB_LOCK_EN
        lock_hold_d  = lock_hold_q;
        lock_own_d   = lock_own_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef SDRAM_ARB_LOCK_EN
                if (lock_hold_q && !held_elig) begin
                    lock_hold_d = 1'b0;
                end
`endif
                if (elig0 || elig1) begin
                    owner_d    = sel;
                    mem_req_d  = 1'b1;
                    mem_we_d   = sel ? p1_we : p0_we;
                    mem_addr_d = sel ? p1_addr : p0_addr;
                    mem_din_d  = sel ? p1_din : p0_din;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    last_grant_d = owner_q;
                    push         = ~mem_we_q;
                    state_d      = IDLE;
`ifdef SDRAM_ARB_LOCK_EN
                    lock_hold_d  = owner_q ? p1_lock : p0_lock;
                    lock_own_d   = owner_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner FIFO: one bit per outstanding read, popped by each returning word
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = owner_q;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + PW'(push) - PW'(pop);
        err_d = err_q | (mem_valid & (cnt_q == '0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            fifo_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

`ifdef SDRAM_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_hold_q <= 1'b0;
            lock_own_q  <= 1'b0;
        end else begin
            lock_hold_q <= lock_hold_d;
            lock_own_q  <= lock_own_d;
        end
    end
`endif

    assign p0_ack     = (state_q == REQ) & mem_ack & ~owner_q;
    assign p1_ack     = (state_q == REQ) & mem_ack & owner_q;
    assign p0_valid   = pop & ~head;
    assign p1_valid   = pop & head;
    assign p0_dout    = mem_dout;
    assign p1_dout    = mem_dout;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign pending    = cnt_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for sdram_port_arbiter.
// Expected grants and read returns are queued at stimulus time and popped on DUT output.
module tb_sdram_port_arbiter;

    localparam int AW = 23;
    localparam int DW = 16;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          p0_req, p0_we, p0_ack, p0_valid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_din, p0_dout;
    logic          p1_req, p1_we, p1_ack, p1_valid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_din, p1_dout;
    logic          mem_req, mem_we, mem_ack, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic [2:0]    pending;
    logic          err_orphan;
`ifdef SDRAM_ARB_LOCK_EN
    logic          p0_lock, p1_lock;
`endif

    typedef struct packed {
        logic          lk;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } txn_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] d;
    } rd_t;

    txn_t q0[$];
    txn_t q1[$];
    int   exp_gnt[$];
    rd_t  exp_rd[$];

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   c0 = 0;
    int   n_ack0 = 0;
    int   n_ack1 = 0;
    int   ctl_lat = 0;
    int   wait_cnt = 0;
    logic ack0_s = 1'b0;
    logic ack1_s = 1'b0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_PENDING(MP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_din    (p0_din),
        .p0_ack    (p0_ack),
        .p0_valid  (p0_valid),
        .p0_dout   (p0_dout),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_din    (p1_din),
        .p1_ack    (p1_ack),
        .p1_valid  (p1_valid),
        .p1_dout   (p1_dout),
`ifdef SDRAM_ARB_LOCK_EN
        .p0_lock   (p0_lock),
        .p1_lock   (p1_lock),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_dout  (mem_dout),
        .pending   (pending),
        .err_orphan(err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic lk, input logic we,
                                input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        txn_t t;
        t.lk = lk;
        t.we = we;
        t.addr = a;
        t.din = d;
        return t;
    endfunction

    // Requesters present their queue head; controller acks after ctl_lat cycles
    task automatic upd();
        txn_t t;
        if (ack0_s && q0.size() > 0) t = q0.pop_front();
        if (ack1_s && q1.size() > 0) t = q1.pop_front();
        ack0_s = 1'b0;
        ack1_s = 1'b0;
        t = (q0.size() > 0) ? q0[0] : '0;
        p0_req = q0.size() > 0;
        p0_we = t.we;
        p0_addr = t.addr;
        p0_din = t.din;
`ifdef SDRAM_ARB_LOCK_EN
        p0_lock = t.lk;
`endif
        t = (q1.size() > 0) ? q1[0] : '0;
        p1_req = q1.size() > 0;
        p1_we = t.we;
        p1_addr = t.addr;
        p1_din = t.din;
`ifdef SDRAM_ARB_LOCK_EN
        p1_lock = t.lk;
`endif
        if (mem_req && !mem_ack) begin
            if (wait_cnt >= ctl_lat) begin
                mem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic step();
        txn_t t;
        rd_t  r;
        int   g;
        @(negedge clk);
        ack0_s = p0_ack;
        ack1_s = p1_ack;
        if (p0_ack || p1_ack) begin
            ack_cyc = cyc;
            chk("ack_onehot", p0_ack & p1_ack, 0);
            chk("gnt_avail", exp_gnt.size() > 0, 1);
            if (exp_gnt.size() > 0) begin
                g = exp_gnt.pop_front();
                chk("gnt_port", p1_ack, g);
            end
            t = '0;
            if (p1_ack && q1.size() > 0) t = q1[0];
            if (p0_ack && q0.size() > 0) t = q0[0];
            chk("gnt_bus", {mem_we, mem_addr, mem_din},
                {t.we, t.addr, t.din});
            if (p1_ack) n_ack1++;
            else n_ack0++;
        end
        if (p0_valid || p1_valid) begin
            chk("rd_onehot", p0_valid & p1_valid, 0);
            chk("rd_avail", exp_rd.size() > 0, 1);
            if (exp_rd.size() > 0) begin
                r = exp_rd.pop_front();
                chk("rd_port", p1_valid, r.port);
                chk("rd_data", p1_valid ? p1_dout : p0_dout, r.d);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        upd();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || mem_req) && n < max) begin
            step();
            n++;
        end
        chk({tag, "_done"},
            (q0.size() == 0 && q1.size() == 0 && !mem_req), 1);
    endtask

    task automatic ret(input logic [DW-1:0] d, input logic port);
        rd_t r;
        r.port = port;
        r.d = d;
        exp_rd.push_back(r);
        mem_valid = 1'b1;
        mem_dout = d;
        step();
        mem_valid = 1'b0;
        mem_dout = '0;
    endtask

    initial begin
        {p0_req, p0_we, p0_addr, p0_din} = '0;
        {p1_req, p1_we, p1_addr, p1_din} = '0;
`ifdef SDRAM_ARB_LOCK_EN
        p0_lock = 1'b0;
        p1_lock = 1'b0;
`endif
        mem_ack = 1'b0;
        mem_valid = 1'b0;
        mem_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_bus", {mem_we, mem_addr, mem_din}, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", err_orphan, 0);
        chk("rst_out", {p0_ack, p1_ack, p0_valid, p1_valid}, 0);
        reset_n = 1'b1;

        // contention: both ports hold writes, port 0 wins the first tie
        ctl_lat = 0;
        q0.push_back(mk(0, 1, 'h100, 'hA000));
        q0.push_back(mk(0, 1, 'h101, 'hA001));
        q1.push_back(mk(0, 1, 'h180, 'hB000));
        q1.push_back(mk(0, 1, 'h181, 'hB001));
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        upd();
        wait_idle("t2", 40);
        chk("t2_acks0", n_ack0, 2);
        chk("t2_acks1", n_ack1, 2);
        chk("t2_gnt_left", exp_gnt.size(), 0);

        // single read from port 0 with 2-cycle controller latency
        ctl_lat = 2;
        q0.push_back(mk(0, 0, 'h10, 0));
        exp_gnt.push_back(0);
        upd();
        c0 = cyc;
        chk("t1_req_c0", mem_req, 0);
        step();
        chk("t1_req_c1", mem_req, 1);
        chk("t1_addr", mem_addr, 'h10);
        chk("t1_we", mem_we, 0);
        wait_idle("t1", 20);
        chk("t1_ack_cyc", ack_cyc - c0, 3);
        chk("t1_pend1", pending, 1);
        ret('hBEEF, 0);
        chk("t1_pend0", pending, 0);

        // owner ordering p1,p0,p1 with a push/pop on the same edge
        ctl_lat = 0;
        q1.push_back(mk(0, 0, 'h200, 0));
        exp_gnt.push_back(1);
        upd();
        wait_idle("t3a", 20);
        q0.push_back(mk(0, 0, 'h300, 0));
        exp_gnt.push_back(0);
        upd();
        wait_idle("t3b", 20);
        chk("t3_pend2", pending, 2);
        q1.push_back(mk(0, 0, 'h400, 0));
        exp_gnt.push_back(1);
        upd();
        step();
        chk("t3_ack_now", mem_ack, 1);
        ret('h1111, 1);
        chk("t3_pend_same", pending, 2);
        chk("t3_q1_done", q1.size(), 0);
        ret('h2222, 0);
        ret('h3333, 1);
        chk("t3_pend0", pending, 0);
        chk("t3_rd_left", exp_rd.size(), 0);

        // FIFO full: reads stall, writes still pass
        for (int i = 0; i < MP; i++) begin
            q1.push_back(mk(0, 0, AW'('h500 + i), 0));
            exp_gnt.push_back(1);
        end
        upd();
        wait_idle("t4a", 40);
        chk("t4_full", pending, MP);
        q1.push_back(mk(0, 0, 'h600, 0));
        q0.push_back(mk(0, 1, 'h700, 'h5A5A));
        exp_gnt.push_back(0);
        upd();
        repeat (6) step();
        chk("t4_wr_gnt", exp_gnt.size(), 0);
        chk("t4_rd_stall", q1.size(), 1);
        chk("t4_idle", mem_req, 0);
        exp_gnt.push_back(1);
        ret('hC001, 1);
        step();
        chk("t4_resume", mem_req, 1);
        wait_idle("t4b", 20);
        chk("t4_full2", pending, MP);
        for (int i = 0; i < MP; i++) begin
            ret(DW'('hC002 + i), 1);
        end
        chk("t4_pend0", pending, 0);

        // orphan return, then reset during REQ
        mem_valid = 1'b1;
        mem_dout = 'hDEAD;
        step();
        mem_valid = 1'b0;
        chk("t5_err", err_orphan, 1);
        chk("t5_pend", pending, 0);
        q0.push_back(mk(0, 0, 'h800, 0));
        exp_gnt.push_back(0);
        upd();
        wait_idle("t5a", 20);
        chk("t5_pend1", pending, 1);
        chk("t5_err_sticky", err_orphan, 1);
        ctl_lat = 100;
        q0.push_back(mk(0, 1, 'h900, 'h1234));
        upd();
        step();
        step();
        chk("t5_in_req", mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_req", mem_req, 0);
        chk("t5_rst_pend", pending, 0);
        chk("t5_rst_err", err_orphan, 0);
        chk("t5_rst_addr", mem_addr, 0);
        q0.delete();
        mem_ack = 1'b0;
        wait_cnt = 0;
        ctl_lat = 0;
        upd();
        step();
        reset_n = 1'b1;
        step();
        chk("t5_quiet", {mem_req, p0_ack, p1_ack}, 0);

`ifdef SDRAM_ARB_LOCK_EN
        // locked burst keeps port 0 ahead of a waiting port 1
        q1.push_back(mk(0, 1, 'hA00, 'h0001));
        q0.push_back(mk(1, 1, 'hB00, 'h0010));
        q0.push_back(mk(1, 1, 'hB01, 'h0011));
        q0.push_back(mk(0, 1, 'hB02, 'h0012));
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        upd();
        wait_idle("t6", 40);
        chk("t6_gnt_left", exp_gnt.size(), 0);
`endif

        chk("end_gnt_left", exp_gnt.size(), 0);
        chk("end_rd_left", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller port between two requesters: port 0 (bridge ROM/data loader) and port 1 (game/video fetch).
- Arbitration is round-robin with a one-transaction-at-a-time request stage.
- Tracks the owner of outstanding reads in an owner FIFO, so returning read data is routed to the requester that issued it.
- Sits between the bridge-side loader / Main fetch units and the SDRAM controller, in the sys_clock domain.

Parameters:
ADDR_W, 23, word address width to the SDRAM controller
DATA_W, 16, data width
MAX_PENDING, 4, maximum outstanding reads (owner FIFO depth, power of 2, >=2)

Ports:
clk  in  1  system clock (sys_clock domain)
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held with addr/we/din stable until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 address
p0_din  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 request accepted (1-cycle pulse)
p0_valid  out  1  port 0 read data valid (1-cycle pulse)
p0_dout  out  DATA_W  port 0 read data
p1_req, p1_we, p1_addr, p1_din, p1_ack, p1_valid, p1_dout  (as port 0)
mem_req  out  1  request to SDRAM controller
mem_we  out  1  write/read to controller
mem_addr  out  ADDR_W  address to controller
mem_din  out  DATA_W  write data to controller
mem_ack  in  1  controller accepted mem_req this cycle
mem_valid  in  1  controller read data valid
mem_dout  in  DATA_W  controller read data
pending  out  $clog2(MAX_PENDING)+1  outstanding read count
err_orphan  out  1  sticky: mem_valid received with no read outstanding

Behaviour:
- Reset (async, reset_n=0): state=IDLE, mem_req=0, mem_we/addr/din=0, last_grant=1 (port 0 wins first tie), owner FIFO empty, pending=0, err_orphan=0. All pX_ack/pX_valid=0. Reset mid-transaction drops mem_req immediately; no ack is issued.
- Eligibility: a port is eligible when req=1 and either we=1 or pending<MAX_PENDING.
- IDLE: if no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port other than last_grant.
  - On grant, register owner, we, addr and din into the mem_* outputs, set mem_req=1, and go to REQ. mem_req rises the cycle after the request is seen.
- REQ: hold mem_* stable while mem_ack=0.
  - On mem_ack=1, pX_ack for the owner is asserted combinationally in the same cycle (pX_ack = state==REQ & mem_ack & owner==X).
  - On the same edge: mem_req<=0, last_grant<=owner, and owner is pushed to the FIFO if the access was a read. Return to IDLE.
  - Minimum spacing between grants is 2 cycles.
- Requester rule: req must drop or present the next request on the cycle after ack. A re-asserted req is a new transaction.
- Read return: pX_valid = mem_valid & FIFO non-empty & head==X (combinational). p0_dout=p1_dout=mem_dout. FIFO pops on mem_valid.
- Simultaneous push and pop: pending unchanged; FIFO order is preserved.
- mem_valid with empty FIFO: no pX_valid, no pop, err_orphan<=1 until reset.
- FIFO full (pending==MAX_PENDING): reads are ineligible and writes are still granted. Arbitration resumes the cycle after a pop.
- pending never exceeds MAX_PENDING and never underflows.

Optional Feature:
- Macro: SDRAM_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs p0_lock and p1_lock (1 bit each).
  - If the owner's lock=1 at its mem_ack, a lock_hold register records that owner.
  - In the next IDLE, if the held owner is eligible, it is granted regardless of round-robin. If it is not eligible, lock_hold clears and round-robin applies.
  - lock_hold resets to clear and is used for multi-word burst sequences.
- Without the macro: the ports are absent and arbitration is pure round-robin.

Test Plan:
- Single read, port 0 only: p0_req at cycle 0 with addr=0x000010 -> mem_req=1 from cycle 1. mem_ack at cycle 3 -> p0_ack at cycle 3, pending=1. mem_valid with mem_dout=0xBEEF -> p0_valid=1, p0_dout=0xBEEF, pending=0.
- Contention: p0 and p1 hold writes continuously -> grants alternate 0,1,0,1 over 4 transactions, and each port receives exactly 2 acks.
- Out-of-band owner ordering: reads issued p1, p0, p1; controller returns 0x1111, 0x2222, 0x3333 -> p1_valid, p0_valid, p1_valid in that order with those data.
- FIFO full (MAX_PENDING=4): 4 unreturned reads from p1, then p1 read and p0 write both requested -> p0 write granted, p1 stalls until first mem_valid, then is granted.
- Orphan and reset: mem_valid with pending=0 -> err_orphan=1 and no pX_valid. Assert reset_n=0 during REQ -> mem_req=0 immediately, err_orphan=0, pending=0.
- SDRAM_ARB_LOCK_EN: p0 issues 3 writes with p0_lock=1 on the first two while p1_req is held -> grants are p0, p0, p0, then p1.
